// File: rtl/alu_defs_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_defs : function-select codes, read-select codes and FSM encoding      |
// |            shared by ALU_32 and its result capture stage.                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_defs;

  localparam logic [4:0] FS_SRL = 5'h0C;
  localparam logic [4:0] FS_SRA = 5'h0D;
  localparam logic [4:0] FS_SLL = 5'h0E;
  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  localparam logic [1:0] RD_R     = 2'd0;
  localparam logic [1:0] RD_LO    = 2'd1;
  localparam logic [1:0] RD_HI    = 2'd2;
  localparam logic [1:0] RD_FLAGS = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_SHIFT  = 2'd1,
    OP_MULDIV = 2'd2
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] fs);
    op_class_e cls;
    case (fs)
      FS_MUL, FS_DIV:         cls = OP_MULDIV;
      FS_SRL, FS_SRA, FS_SLL: cls = OP_SHIFT;
      default:                cls = OP_ALU;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_reg.sv
// +--------------------------------------------------------------------------+
// | alu_result_reg : captures ALU_32 results and flags, waiting a fixed      |
// |                  settle time for MUL/DIV; single combinational read port.|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_result_reg
  import alu_defs::*;
#(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  FS,
  input  logic [31:0] Y_HI,
  input  logic [31:0] Y_LO,
  input  logic        C,
  input  logic        V,
  input  logic        N,
  input  logic        Z,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done
);

  localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      r_q, r_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [3:0]       flags_q, flags_d;   // {C,V,N,Z}
  logic             done_q, done_d;

  op_class_e op_class;
  logic      accept;

  assign op_class = classify(FS);
  assign accept   = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op_class == OP_MULDIV) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_WAIT);
  end

  // MUL and DIV capture identically, so FS is only needed to pick the wait length.
  always_comb begin
    cnt_d   = cnt_q;
    r_d     = r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (accept) begin
      case (op_class)
        OP_ALU: begin
          r_d     = Y_LO;
          flags_d = {C, V, N, Z};
          done_d  = 1'b1;
        end
        OP_SHIFT: begin
          r_d        = Y_LO;
          flags_d[3] = C;
          flags_d[0] = Z;
          done_d     = 1'b1;
        end
        default: begin
          cnt_d = (FS == FS_DIV) ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
        end
      endcase
    end else if (state_q == ST_WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        hi_d       = Y_HI;
        lo_d       = Y_LO;
        flags_d[1] = N;
        flags_d[0] = Z;
        done_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      r_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

  always_comb begin
    case (rd_sel)
      RD_R:     rd_data = r_q;
      RD_LO:    rd_data = lo_q;
      RD_HI:    rd_data = hi_q;
      RD_FLAGS: rd_data = {28'b0, flags_q};
      default:  rd_data = '0;
    endcase
  end

endmodule

`default_nettype wire
